// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// instruction field width and the halt instruction pattern.
package fetch_pkg;

  localparam int FIELD_W = 3;

  localparam logic [FIELD_W-1:0] HALT_OP = 3'b111;
  localparam logic [FIELD_W-1:0] HALT_R1 = 3'b111;
  localparam logic [FIELD_W-1:0] HALT_R2 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and a saturation limit.
// The clear input wins over the enable input.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE -> RUN on start, RUN -> DONE on halt or on
// hitting the retired-instruction limit. Optional macro: FETCH_CYCLE_COUNT_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | fetching; pc advances, holds on stall, redirects on branch
// DONE    | finished (halt or limit); pc and flags held until start
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          PC_BITS    = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int          MAX_INSNS  = 4095
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_BITS-1:0] branch_target,
  input  logic [FIELD_W-1:0] ins_op,
  input  logic [FIELD_W-1:0] ins_r1,
  input  logic [FIELD_W-1:0] ins_r2,
  output logic [PC_BITS-1:0] pc,
  output logic               fetch_valid,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [15:0]        cycle_count
);

  localparam int RET_W = (MAX_INSNS < 1) ? 1 : $clog2(MAX_INSNS + 1);

  state_e             state_q;
  logic [PC_BITS-1:0] pc_q;
  logic               done_q;
  logic               timeout_q;
  logic [RET_W-1:0]   retire_cnt;

  logic in_run;
  logic launch;
  logic halt;
  logic retire;
  logic limit_hit;

  assign in_run    = (state_q == ST_RUN);
  assign launch    = !in_run && start;
  assign halt      = (ins_op == HALT_OP) && (ins_r1 == HALT_R1) && (ins_r2 == HALT_R2);
  assign retire    = in_run && !halt && !stall;
  // The retire that lands on the limit ends the run; that retire still counts.
  assign limit_hit = retire && (retire_cnt == RET_W'(MAX_INSNS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            pc_q      <= PC_BITS'(START_ADDR);
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (!stall) begin
            if (limit_hit) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end else if (branch_taken) begin
              pc_q <= branch_target;
            end else begin
              pc_q <= pc_q + PC_BITS'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (RET_W),
    .LIMIT (RET_W'(MAX_INSNS))
  ) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (retire),
    .count (retire_cnt)
  );

`ifdef FETCH_CYCLE_COUNT_EN
  sat_counter #(
    .WIDTH (16),
    .LIMIT (16'hFFFF)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (in_run),
    .count (cycle_count)
  );
`else
  assign cycle_count = 16'h0000;
`endif

  assign pc          = pc_q;
  assign fetch_valid = in_run;
  assign busy        = in_run;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_BITS, default 12, SHALL set the program-counter width.
REQ-002 Parameter START_ADDR, default 0, SHALL set the PC loaded on every start.
REQ-003 Parameter MAX_INSNS, default 4095, SHALL set the retired-instruction limit before timeout.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin program execution.
REQ-007 stall  in  1  hold the PC this cycle.
REQ-008 branch_taken  in  1  redirect the PC to branch_target.
REQ-009 branch_target  in  PC_BITS  absolute redirect address.
REQ-010 ins_op, ins_r1, ins_r2  in  3 each  decoded fields of the instruction at the current pc, valid in the same cycle.
REQ-011 pc  out  PC_BITS  fetch address driven to instruction memory.
REQ-012 fetch_valid  out  1  the fields at pc are a live instruction.
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  program finished, held until the next start.
REQ-015 timeout  out  1  done was caused by the MAX_INSNS limit.
REQ-016 cycle_count  out  16  RUN-cycle count (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE/DONE with start=1: next state RUN; pc<=START_ADDR; done, timeout and counters cleared.
REQ-019 start SHALL be ignored in RUN.
REQ-020 fetch_valid and busy SHALL equal (state==RUN).
REQ-021 Halt encoding SHALL be ins_op=ins_r1=ins_r2=3'b111.
REQ-022 RUN update priority per cycle: halt > stall > branch > increment.
REQ-023 RUN with halt: next state DONE; pc holds; timeout=0.
REQ-024 RUN with stall and no halt: pc holds; no retire.
REQ-025 RUN with branch_taken, no stall, no halt: pc<=branch_target; one retire.
REQ-026 Otherwise in RUN: pc<=pc+1 modulo 2^PC_BITS (all-ones wraps to 0); one retire.
REQ-027 Retire counter: width ceil(log2(MAX_INSNS+1)); counts retires; when a retire brings it to MAX_INSNS without halt, next state DONE with timeout=1 and pc holds.
REQ-028 If halt and the limit coincide, halt SHALL win: timeout=0.
REQ-029 DONE SHALL hold pc, done=1, timeout until start or reset.
REQ-030 Latency: pc and state changes SHALL be visible one cycle after the triggering inputs.

Reset
REQ-031 reset=1 at an edge SHALL force state IDLE, pc=0, done=0, timeout=0, retire counter=0 and cycle_count=0, overriding start and any in-flight operation.
REQ-032 In IDLE after reset, fetch_valid=0 and busy=0.

Configuration
REQ-033 Macro FETCH_CYCLE_COUNT_EN defined: cycle_count SHALL increment every RUN cycle, stalled or not, saturate at 16'hFFFF, clear on start, and hold in DONE.
REQ-034 Macro undefined: cycle_count port SHALL remain and SHALL be constant 0, and no counter logic SHALL be built.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum, HALT_OP/HALT_R1/HALT_R2 constants and the 3-bit field width constant.
REQ-036 The retire/cycle counting SHALL use one sub-module, sat_counter (parameterised width, clear, enable, saturation limit).

Verification
REQ-037 Reset, then start; halt at address 3 -> pc 0,1,2,3; done=1 on the cycle after pc=3; timeout=0; cycle_count=4 (macro on).
REQ-038 stall=1 for 2 cycles at pc=1 -> pc holds at 1 for 2 cycles, then 2; cycle_count includes the stalls.
REQ-039 branch_taken=1 with stall=1 at pc=5 -> pc stays 5; next cycle branch_taken=1 alone, target 12'h0A0 -> pc=12'h0A0.
REQ-040 PC_BITS=4, MAX_INSNS=20, no halt -> pc wraps 15->0; done=1 and timeout=1 after 20 retires.
REQ-041 reset asserted mid-RUN at pc=7 -> next cycle IDLE, pc=0, busy=0; start while in RUN -> no effect.
REQ-042 In DONE, start pulse -> RUN, pc=START_ADDR, done=0 next cycle.
